// File: rtl/shade_stream_out_pkg.sv
// Shared definitions for the shading output stream: pixel format,
// default raster geometry and the FIFO head-room needed by the ray issuer.
package shade_stream_out_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int PIX_WIDTH_DEF    = $bits(rgb888_t);
  localparam int IMG_W_DEF        = 640;
  localparam int IMG_H_DEF        = 480;
  localparam int FIFO_DEPTH_DEF   = 32;

  // Rays already in flight between issue and shade still land after
  // almost_full is seen, so the margin must cover that pipeline depth.
  localparam int SHADE_PIPE_DEPTH = 8;
  localparam int AF_MARGIN_DEF    = SHADE_PIPE_DEPTH;

  // Counter width that stays legal for a dimension of 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/shade_stream_out_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. Head entry is presented from
// the registered storage, so there is no path from write data to read data.
// Writes arriving while full are dropped and flagged, even if a read
// frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_nxt,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_wr_en && !w_full;
  assign w_pop   = i_rd_en && (r_count != '0);
  assign o_drop  = i_wr_en && w_full;

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  assign o_valid     = (r_count != '0);
  assign o_rd_data   = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/shade_stream_out.sv
// Output end of the shading pipeline: buffers non-stallable shaded pixels
// and presents them as an AXI4-Stream video master with raster-derived
// start-of-frame (tuser) and end-of-line (tlast) markers.
module shade_stream_out
  import shade_stream_out_pkg::*;
#(
  parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [PIX_WIDTH-1:0]          i_pix_in,
  input  logic                          i_pix_valid,
  output logic                          o_almost_full,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [PIX_WIDTH-1:0]          o_m_axis_tdata,
  output logic                          o_m_axis_tvalid,
  input  logic                          i_m_axis_tready,
  output logic                          o_m_axis_tuser,
  output logic                          o_m_axis_tlast
);

  localparam int XW       = clog2_min1(IMG_W);
  localparam int YW       = clog2_min1(IMG_H);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic                 r_almost_full;
  logic                 r_overflow;
  logic                 w_valid;
  logic [PIX_WIDTH-1:0] w_head;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_x_last;
  logic                 w_y_last;

  sync_fifo_fwft #(
    .WIDTH (PIX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (i_pix_valid),
    .i_wr_data   (i_pix_in),
    .i_rd_en     (i_m_axis_tready),
    .o_valid     (w_valid),
    .o_rd_data   (w_head),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt),
    .o_drop      (w_drop)
  );

  assign w_pop    = w_valid && i_m_axis_tready;
  assign w_x_last = (r_x == XW'(IMG_W - 1));
  assign w_y_last = (r_y == YW'(IMG_H - 1));

  // Raster position of the pixel at the FIFO head; advances only on transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Back-pressure flag from post-update occupancy, and sticky drop flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= CW'(AF_LEVEL));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_almost_full   = r_almost_full;
  assign o_overflow      = r_overflow;
  assign o_fifo_level    = w_count;
  assign o_m_axis_tvalid = w_valid;
  assign o_m_axis_tdata  = w_head;
  assign o_m_axis_tuser  = w_valid && (r_x == '0) && (r_y == '0);
  assign o_m_axis_tlast  = w_valid && w_x_last;

endmodule

// File: tb/tb_shade_stream_out.sv
// Directed bench for shade_stream_out with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_shade_stream_out;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic        clk;
  logic        rst;
  logic [23:0] pix_in;
  logic        pix_valid;
  logic        almost_full;
  logic        overflow;
  logic [3:0]  fifo_level;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  int checks = 0;
  int errors = 0;

  shade_stream_out #(
    .PIX_WIDTH  (24),
    .IMG_W      (W),
    .IMG_H      (H),
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN  (AFM)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pix_in        (pix_in),
    .i_pix_valid     (pix_valid),
    .o_almost_full   (almost_full),
    .o_overflow      (overflow),
    .o_fifo_level    (fifo_level),
    .o_m_axis_tdata  (tdata),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tuser  (tuser),
    .o_m_axis_tlast  (tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pixel queue, count of transfers since frame start, flags.
  logic [23:0] mq[$];
  int          midx = 0;
  bit          movf = 0;
  bit          maf  = 0;
  bit          live = 0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst) begin
      mq.delete();
      midx = 0;
      movf = 0;
      maf  = 0;
      live = 1;
    end else if (live) begin
      do_pop  = (mq.size() != 0) && tready;
      do_push = pix_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        midx = (midx + 1) % (W * H);
      end
      if (do_push) mq.push_back(pix_in);
      else if (pix_valid) movf = 1;
      maf = (mq.size() >= DEPTH - AFM);
    end
  end

  // Log of transfers seen on the stream, for the literal checks.
  logic [23:0] log_d[$];
  bit          log_u[$];
  bit          log_l[$];

  always @(negedge clk) begin
    if (live) begin
      chk("tvalid", 32'(tvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("tdata", 32'(tdata), 32'(mq[0]));
        chk("tuser", 32'(tuser), 32'(midx == 0));
        chk("tlast", 32'(tlast), 32'((midx % W) == W - 1));
      end
      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("almost_full", 32'(almost_full), 32'(maf));
      chk("overflow", 32'(overflow), 32'(movf));
      if (tvalid && tready) begin
        log_d.push_back(tdata);
        log_u.push_back(tuser);
        log_l.push_back(tlast);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_in    = 24'(first + i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic chk_log(input string name, input int first, input int n);
    chk({name, "_len"}, 32'(log_d.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_d.size()) chk({name, "_data"}, 32'(log_d[i]), 32'(first + i));
    end
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 24'hFFFFFF;
    tready    = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    pix_valid = 1'b0;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_tdata", 32'(tdata), 0);

    // Frame markers across a full 4x2 frame plus one wrap pixel.
    tready = 1'b1;
    push_seq(1, 9);
    tick(); tick(); tick();
    chk_log("frm", 1, 9);
    for (int i = 0; i < 9; i++) begin
      if (i < log_u.size()) begin
        chk("frm_tuser", 32'(log_u[i]), 32'(i == 0 || i == 8));
        chk("frm_tlast", 32'(log_l[i]), 32'(i == 3 || i == 7));
      end
    end

    // Backpressure and almost_full threshold.
    log_d.delete(); log_u.delete(); log_l.delete();
    tready = 1'b0;
    push_seq(1, 6);
    chk("bp_af", 32'(almost_full), 1);
    chk("bp_level", 32'(fifo_level), 6);
    chk("bp_tdata", 32'(tdata), 32'h1);
    tick(); tick();
    chk("bp_hold", 32'(tdata), 32'h1);
    tready = 1'b1;
    tick();
    chk("bp_level5", 32'(fifo_level), 5);
    chk("bp_af_off", 32'(almost_full), 0);
    for (int i = 0; i < 6; i++) tick();
    chk_log("bp", 1, 6);

    // Overflow, then full with simultaneous push and pop.
    log_d.delete(); log_u.delete(); log_l.delete();
    tready = 1'b0;
    push_seq(1, 10);
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    tready    = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 24'h0000EE;
    tick();
    pix_valid = 1'b0;
    chk("full_pp_level", 32'(fifo_level), 7);
    chk("full_pp_ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) tick();
    chk_log("ovf", 1, 8);
    chk("ovf_sticky", 32'(overflow), 1);

    // Mid-frame reset restarts the raster.
    tready = 1'b0;
    push_seq(16, 5);
    tready = 1'b1;
    tick(); tick(); tick();
    tready = 1'b0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    chk("mrst_tvalid", 32'(tvalid), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    pix_valid = 1'b1;
    pix_in    = 24'hABCDEF;
    tick();
    pix_valid = 1'b0;
    chk("mrst_tvalid1", 32'(tvalid), 1);
    chk("mrst_tdata", 32'(tdata), 32'hABCDEF);
    chk("mrst_tuser", 32'(tuser), 1);
    chk("mrst_tlast", 32'(tlast), 0);
    tready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
